// File: rtl/apb_slave_regfile_if.sv
// rtl/apb_slave_regfile_if.sv - APB bus bundle between a master and the register file
interface apb_slave_regfile_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB word register file with ID register, wait states and error/write counters
module apb_slave_regfile #(
  parameter int          ADDR_WIDTH  = 8,
  parameter int          DATA_WIDTH  = 32,
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                PCLK,
  input  logic                PRESET,
  apb_slave_regfile_if.slave  apb,
  output logic [15:0]         wr_count,
  output logic [7:0]          err_count
);
  localparam int         IDX_W     = $clog2(NUM_REGS);
  localparam int         LANES     = DATA_WIDTH / 8;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state, state_nxt;
  logic [3:0]            wait_cnt, wait_cnt_nxt;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  addr_err;
  logic                  ready;
  logic                  commit;

  assign idx = apb.PADDR[IDX_W+1:2];

  // Unaligned, beyond the register window, or a write to the read-only ID word.
  assign addr_err = (apb.PADDR[1:0] != 2'b00)
                 || ((apb.PADDR >> (IDX_W + 2)) != '0)
                 || (apb.PWRITE && (idx == '0));

  assign ready  = (state == ACCESS) && (wait_cnt == WAIT_LAST);
  assign commit = ready && apb.PWRITE && !addr_err;

  assign rd_word     = (idx == '0) ? ID_VALUE : regs[idx];
  assign apb.PREADY  = ready;
  assign apb.PSLVERR = ready && addr_err;
  assign apb.PRDATA  = (ready && !apb.PWRITE && !addr_err) ? rd_word : '0;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      IDLE: begin
        if (apb.PSEL && !apb.PENABLE) state_nxt = SETUP;
      end
      SETUP: begin
        state_nxt    = ACCESS;
        wait_cnt_nxt = '0;
      end
      ACCESS: begin
        if (!ready) wait_cnt_nxt = wait_cnt + 4'd1;
        // Dropping PSEL before PREADY abandons the transfer without a commit.
        if (ready || !apb.PSEL) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (commit && (wr_count != 16'hFFFF)) wr_count <= wr_count + 16'd1;
      if (ready && addr_err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

  // Index 0 is never committed because writes to it always error.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit) begin
      for (int b = 0; b < LANES; b++) begin
        if (apb.PSTRB[b]) regs[idx][8*b +: 8] <= apb.PWDATA[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - self-checking bench for apb_slave_regfile
module tb_apb_slave_regfile;
  localparam logic [31:0] ID = 32'hA5B0_0001;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [15:0] wr_count, wr_count_fast, cur_wr;
  logic [7:0]  err_count, err_count_fast, cur_err;
  logic        tgt, psel, penable, pwrite, seen;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;

  vec_t vecs [16];
  exp_t sb [$];
  int   exp_wr [2];
  int   exp_errs [2];
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 PCLK = ~PCLK;

  apb_slave_regfile_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();
  apb_slave_regfile_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus_fast ();

  apb_slave_regfile #(.WAIT_CYCLES(1)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .apb(bus), .wr_count(wr_count), .err_count(err_count)
  );

  apb_slave_regfile #(.WAIT_CYCLES(0)) dut_fast (
    .PCLK(PCLK), .PRESET(PRESET), .apb(bus_fast), .wr_count(wr_count_fast), .err_count(err_count_fast)
  );

  assign bus.PSEL         = psel & ~tgt;
  assign bus_fast.PSEL    = psel & tgt;
  assign bus.PENABLE      = penable;
  assign bus_fast.PENABLE = penable;
  assign bus.PWRITE       = pwrite;
  assign bus_fast.PWRITE  = pwrite;
  assign bus.PADDR        = paddr;
  assign bus_fast.PADDR   = paddr;
  assign bus.PWDATA       = pwdata;
  assign bus_fast.PWDATA  = pwdata;
  assign bus.PSTRB        = pstrb;
  assign bus_fast.PSTRB   = pstrb;

  assign pready  = tgt ? bus_fast.PREADY  : bus.PREADY;
  assign pslverr = tgt ? bus_fast.PSLVERR : bus.PSLVERR;
  assign prdata  = tgt ? bus_fast.PRDATA  : bus.PRDATA;
  assign cur_wr  = tgt ? wr_count_fast    : wr_count;
  assign cur_err = tgt ? err_count_fast   : err_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [31:0] exp_rdata, input logic exp_err,
                      input string tag);
    exp_t e;
    int   n;
    bit   done;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb.push_back(e);
    @(posedge PCLK); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    @(posedge PCLK); #1;
    penable = 1'b1;
    n = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      @(posedge PCLK);
      @(negedge PCLK);
      n++;
      if (pready) begin
        e = sb.pop_front();
        check({tag, " prdata"}, prdata, e.rdata);
        check({tag, " pslverr"}, 32'(pslverr), 32'(e.err));
        check({tag, " ready cycle"}, n, tgt ? 1 : 2);
        done = 1'b1;
      end else begin
        check({tag, " wait prdata"}, prdata, 32'h0);
        check({tag, " wait pslverr"}, 32'(pslverr), 32'h0);
      end
    end
    if (!done) begin
      n_total++;
      $display("FAIL %s timeout: no PREADY after %0d cycles, required within 20", tag, n);
      void'(sb.pop_front());
    end
    if (wr && !exp_err && exp_wr[tgt] < 65535) exp_wr[tgt]++;
    if (exp_err && exp_errs[tgt] < 255) exp_errs[tgt]++;
  endtask

  task automatic idle_and_check(input string tag);
    @(posedge PCLK); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    @(negedge PCLK);
    check({tag, " wr_count"}, 32'(cur_wr), exp_wr[tgt]);
    check({tag, " err_count"}, 32'(cur_err), exp_errs[tgt]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tgt = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; seen = 1'b0;
    exp_wr = '{0, 0};
    exp_errs = '{0, 0};
    PRESET = 1'b1;

    vecs[0]  = '{1'b1, 8'h04, 32'hDEADBEEF, 4'hF,    32'h0,        1'b0};
    vecs[1]  = '{1'b0, 8'h04, 32'h0,        4'h0,    32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 8'h08, 32'h11223344, 4'b0101, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 8'h08, 32'h0,        4'h0,    32'h00220044, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 32'h0,        4'h0,    ID,           1'b0};
    vecs[5]  = '{1'b1, 8'h00, 32'h12345678, 4'hF,    32'h0,        1'b1};
    vecs[6]  = '{1'b0, 8'h00, 32'h0,        4'h0,    ID,           1'b0};
    vecs[7]  = '{1'b1, 8'h41, 32'hFFFFFFFF, 4'hF,    32'h0,        1'b1};
    vecs[8]  = '{1'b1, 8'h40, 32'hFFFFFFFF, 4'hF,    32'h0,        1'b1};
    vecs[9]  = '{1'b0, 8'h40, 32'h0,        4'h0,    32'h0,        1'b1};
    vecs[10] = '{1'b1, 8'h0C, 32'h0000AA00, 4'h0,    32'h0,        1'b0};
    vecs[11] = '{1'b0, 8'h0C, 32'h0,        4'h0,    32'h0,        1'b0};
    vecs[12] = '{1'b1, 8'h3C, 32'hCAFEF00D, 4'b1100, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 8'h3C, 32'h0,        4'h0,    32'hCAFE0000, 1'b0};
    vecs[14] = '{1'b0, 8'h04, 32'h0,        4'h0,    32'hDEADBEEF, 1'b0};
    vecs[15] = '{1'b0, 8'h43, 32'h0,        4'h0,    32'h0,        1'b1};

    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    check("reset pready", 32'(bus.PREADY), 32'h0);
    check("reset pslverr", 32'(bus.PSLVERR), 32'h0);
    check("reset prdata", bus.PRDATA, 32'h0);
    check("reset wr_count", 32'(wr_count), 32'h0);
    check("reset err_count", 32'(err_count), 32'h0);
    PRESET = 1'b0;

    for (int i = 0; i < 16; i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].rdata, vecs[i].err,
           $sformatf("vec%0d", i));
      idle_and_check($sformatf("vec%0d", i));
    end

    // Back-to-back: the read's setup phase follows the write's PREADY cycle directly.
    xfer(1'b1, 8'h10, 32'h01020304, 4'hF, 32'h0, 1'b0, "b2b write");
    xfer(1'b0, 8'h10, 32'h0, 4'h0, 32'h01020304, 1'b0, "b2b read");
    idle_and_check("b2b");

    // PENABLE high while idle must not start a transfer.
    @(posedge PCLK); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h14; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    seen = 1'b0;
    repeat (6) begin
      @(negedge PCLK);
      seen = seen | pready;
    end
    check("penable idle pready", 32'(seen), 32'h0);
    idle_and_check("penable idle");
    xfer(1'b0, 8'h14, 32'h0, 4'h0, 32'h0, 1'b0, "penable idle readback");
    idle_and_check("penable idle readback");

    // Abort: PSEL dropped in the first ACCESS cycle.
    @(posedge PCLK); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h55AA55AA; pstrb = 4'hF;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(posedge PCLK); #1;
    psel = 1'b0;
    @(negedge PCLK);
    check("abort pready", 32'(pready), 32'h0);
    idle_and_check("abort");
    xfer(1'b0, 8'h0C, 32'h0, 4'h0, 32'h0, 1'b0, "abort readback");
    idle_and_check("abort readback");

    // Zero wait states, then saturate err_count.
    tgt = 1'b1;
    xfer(1'b1, 8'h10, 32'h0BADCAFE, 4'hF, 32'h0, 1'b0, "fast write");
    xfer(1'b0, 8'h10, 32'h0, 4'h0, 32'h0BADCAFE, 1'b0, "fast read");
    idle_and_check("fast");
    for (int i = 0; i < 260; i++) begin
      xfer(1'b1, 8'h00, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, $sformatf("sat%0d", i));
    end
    idle_and_check("saturate");
    tgt = 1'b0;

    // Reset asserted in the PREADY cycle of a write.
    @(posedge PCLK); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 32'h0BADF00D; pstrb = 4'hF;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(posedge PCLK);
    @(posedge PCLK); #3;
    check("pre-reset pready", 32'(pready), 32'h1);
    PRESET = 1'b1;
    #1;
    check("mid reset pready", 32'(bus.PREADY), 32'h0);
    check("mid reset pslverr", 32'(bus.PSLVERR), 32'h0);
    check("mid reset prdata", bus.PRDATA, 32'h0);
    check("mid reset wr_count", 32'(wr_count), 32'h0);
    check("mid reset err_count", 32'(err_count), 32'h0);
    check("mid reset fast err_count", 32'(err_count_fast), 32'h0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    exp_wr = '{0, 0};
    exp_errs = '{0, 0};
    for (int i = 0; i < 16; i++) begin
      xfer(1'b0, 8'(i * 4), 32'h0, 4'h0, (i == 0) ? ID : 32'h0, 1'b0, $sformatf("post-reset r%0d", i));
    end
    idle_and_check("post-reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/apb_slave_regfile.md
APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, meaning PADDR width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning PWDATA/PRDATA width; only 32 is supported.
REQ-003 The block SHALL have parameter NUM_REGS, default 16, meaning word registers including index 0; power of 2, maximum 2^(ADDR_WIDTH-2).
REQ-004 The block SHALL have parameter WAIT_CYCLES, default 1, meaning PREADY-low cycles per ACCESS phase; range 0-15.
REQ-005 The block SHALL have parameter ID_VALUE, default 32'hA5B0_0001, meaning the read-only contents of register 0.
REQ-006 The block SHALL have port PCLK, input, 1 bit: clock; all state changes on its rising edge.
REQ-007 The block SHALL have port PRESET, input, 1 bit: reset, asynchronous, active-high.
REQ-008 The block SHALL have port PADDR, input, ADDR_WIDTH bits: byte address.
REQ-009 The block SHALL have port PSEL, input, 1 bit: slave select.
REQ-010 The block SHALL have port PENABLE, input, 1 bit: ACCESS phase indicator.
REQ-011 The block SHALL have port PWRITE, input, 1 bit: 1 = write, 0 = read.
REQ-012 The block SHALL have port PWDATA, input, DATA_WIDTH bits: write data.
REQ-013 The block SHALL have port PSTRB, input, DATA_WIDTH/8 bits: byte-lane write enables.
REQ-014 The block SHALL have port PRDATA, output, DATA_WIDTH bits: read data.
REQ-015 The block SHALL have port PREADY, output, 1 bit: transfer completes this cycle.
REQ-016 The block SHALL have port PSLVERR, output, 1 bit: transfer error.
REQ-017 The block SHALL have port wr_count, output, 16 bits: saturating count of committed writes.
REQ-018 The block SHALL have port err_count, output, 8 bits: saturating count of error responses.

Function
REQ-019 FSM SHALL have states IDLE, SETUP, ACCESS: IDLE->SETUP when PSEL=1 and PENABLE=0; SETUP->ACCESS unconditionally; ACCESS->IDLE on PREADY=1 or PSEL=0.
REQ-020 Wait counter SHALL clear in SETUP, increment each ACCESS cycle with PREADY=0, and PREADY SHALL equal (state==ACCESS and counter==WAIT_CYCLES) from registered state.
REQ-021 With WAIT_CYCLES=0, PREADY SHALL be 1 in the first ACCESS cycle (two-cycle transfer).
REQ-022 Register index SHALL be PADDR[log2(NUM_REGS)+1:2]; error SHALL apply when PADDR[1:0]!=0, when any PADDR bit above the index is 1, or on a write to index 0.
REQ-023 PSLVERR SHALL equal error when PREADY=1 and SHALL be 0 otherwise.
REQ-024 A write SHALL commit at the edge where PREADY=1, PWRITE=1 and error=0, updating byte lane i only where PSTRB[i]=1.
REQ-025 A write with PSTRB=0 and no error SHALL complete without PSLVERR, leave data unchanged and increment wr_count.
REQ-026 PRDATA SHALL present the indexed register (ID_VALUE for index 0) when PREADY=1, PWRITE=0 and error=0, and SHALL be 0 otherwise.
REQ-027 wr_count SHALL increment on each committed write and err_count on each PREADY&PSLVERR cycle, each holding at all-ones.
REQ-028 PSEL=0 during ACCESS before PREADY SHALL abort the transfer: return to IDLE, no commit, no counter change.
REQ-029 PENABLE=1 while the FSM is in IDLE SHALL be ignored, with no transfer started.
REQ-030 Back-to-back transfers SHALL be supported: the cycle after PREADY=1 may be a new SETUP.

Reset
REQ-031 PRESET=1 SHALL immediately force state IDLE, wait counter 0, registers 1..NUM_REGS-1 to 0, wr_count 0, err_count 0, PREADY 0, PSLVERR 0, PRDATA 0.
REQ-032 Reset asserted mid-ACCESS SHALL discard the pending transfer with no commit.

Verification
REQ-033 Write 0xDEADBEEF to 0x04 with PSTRB=4'hF, then read 0x04 -> PREADY high in the 2nd ACCESS cycle, PRDATA=0xDEADBEEF, PSLVERR=0, wr_count=1.
REQ-034 Write 0x11223344 to 0x08 with PSTRB=4'b0101 over prior value 0 -> readback 0x00220044.
REQ-035 Read 0x00 -> 0xA5B00001; write 0x00 -> PSLVERR=1, readback unchanged, err_count=1.
REQ-036 Access 0x41 (unaligned) and 0x40 (out of range, NUM_REGS=16) -> PSLVERR=1 on each, err_count=2, no register changed.
REQ-037 Write to 0x0C, PSEL dropped in the 1st ACCESS cycle (WAIT_CYCLES=1) -> no commit, FSM in IDLE, wr_count unchanged.
REQ-038 PRESET pulsed mid-ACCESS after prior writes -> all outputs 0 immediately, all registers read 0 except index 0.
